// File: rtl/ex_pipe_ctrl_if.sv
// Execute-stage sequencing bundle: hazard/op status from the pipeline in,
// stall/flush/bubble controls and the stall performance counter out.
interface ex_pipe_ctrl_if #(
    parameter int CNT_W = 16
) ();
    logic             id_valid_i;
    logic [4:0]       id_rs1_i;
    logic [4:0]       id_rs2_i;
    logic             ex_MemRead_i;
    logic [4:0]       ex_waddr_i;
    logic             ex_multi_i;
    logic             mem_branch_taken_i;
    logic             pc_stall_o;
    logic             ifid_stall_o;
    logic             idex_stall_o;
    logic             ifid_flush_o;
    logic             idex_flush_o;
    logic             exmem_bubble_o;
    logic             ex_busy_o;
    logic             ex_done_o;
    logic [CNT_W-1:0] stall_cnt_o;

    // Pipeline side: reports ID/EX/MEM status, consumes the controls.
    modport master (
        output id_valid_i, id_rs1_i, id_rs2_i, ex_MemRead_i, ex_waddr_i,
               ex_multi_i, mem_branch_taken_i,
        input  pc_stall_o, ifid_stall_o, idex_stall_o, ifid_flush_o,
               idex_flush_o, exmem_bubble_o, ex_busy_o, ex_done_o, stall_cnt_o
    );

    // Controller side.
    modport slave (
        input  id_valid_i, id_rs1_i, id_rs2_i, ex_MemRead_i, ex_waddr_i,
               ex_multi_i, mem_branch_taken_i,
        output pc_stall_o, ifid_stall_o, idex_stall_o, ifid_flush_o,
               idex_flush_o, exmem_bubble_o, ex_busy_o, ex_done_o, stall_cnt_o
    );
endinterface

// File: rtl/ex_pipe_ctrl.sv
// Execute-stage pipeline sequencer: load-use stalls, fixed-latency
// multi-cycle EX ops and MEM-resolved branch flushes, plus a saturating
// stall-cycle counter.
//
// state | meaning
// RUN   | normal flow; load-use detection and multi-cycle entry
// MULTI | multi-cycle op holding EX; cnt counts remaining stall cycles
module ex_pipe_ctrl #(
    parameter int MUL_LAT = 4,
    parameter int CNT_W   = 16
) (
    input  logic          clock,
    input  logic          reset,
    ex_pipe_ctrl_if.slave pipe
);
    typedef enum logic {
        RUN   = 1'b0,
        MULTI = 1'b1
    } state_t;

    // Entry cycle is one of the MUL_LAT cycles and the done cycle another.
    localparam logic [3:0] CNT_INIT = 4'(MUL_LAT - 2);

    state_t           state, state_nxt;
    logic [3:0]       cnt, cnt_nxt;
    logic [CNT_W-1:0] stall_cnt;
    logic             flush;
    logic             load_use;
    logic             pc_stall, ifid_stall, idex_stall;
    logic             ifid_flush, idex_flush, exmem_bubble;
    logic             ex_busy, ex_done;

    assign flush    = pipe.mem_branch_taken_i;
    // Register 31 is XZR, so a load targeting it never creates a dependency.
    assign load_use = pipe.id_valid_i && pipe.ex_MemRead_i
                   && (pipe.ex_waddr_i != 5'd31)
                   && ((pipe.id_rs1_i == pipe.ex_waddr_i)
                    || (pipe.id_rs2_i == pipe.ex_waddr_i));

    // State and latency counter registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= RUN;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state: a flush aborts any op in flight regardless of state.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (flush) begin
            state_nxt = RUN;
            cnt_nxt   = 4'd0;
        end else begin
            case (state)
                RUN: begin
                    if (pipe.ex_multi_i) begin
                        state_nxt = MULTI;
                        cnt_nxt   = CNT_INIT;
                    end
                end
                MULTI: begin
                    if (cnt == 4'd0) begin
                        state_nxt = RUN;
                    end else begin
                        cnt_nxt = cnt - 4'd1;
                    end
                end
                default: begin
                    state_nxt = RUN;
                    cnt_nxt   = 4'd0;
                end
            endcase
        end
    end

    // Output decode: flush > multi-cycle > load-use; all quiet while in reset.
    always_comb begin
        pc_stall     = 1'b0;
        ifid_stall   = 1'b0;
        idex_stall   = 1'b0;
        ifid_flush   = 1'b0;
        idex_flush   = 1'b0;
        exmem_bubble = 1'b0;
        ex_busy      = 1'b0;
        ex_done      = 1'b0;
        if (reset) begin
            if (flush) begin
                ifid_flush   = 1'b1;
                idex_flush   = 1'b1;
                exmem_bubble = 1'b1;
            end else begin
                case (state)
                    RUN: begin
                        if (pipe.ex_multi_i) begin
                            pc_stall     = 1'b1;
                            ifid_stall   = 1'b1;
                            idex_stall   = 1'b1;
                            exmem_bubble = 1'b1;
                            ex_busy      = 1'b1;
                        end else if (load_use) begin
                            pc_stall   = 1'b1;
                            ifid_stall = 1'b1;
                            idex_flush = 1'b1;
                        end
                    end
                    MULTI: begin
                        ex_busy = 1'b1;
                        if (cnt != 4'd0) begin
                            pc_stall     = 1'b1;
                            ifid_stall   = 1'b1;
                            idex_stall   = 1'b1;
                            exmem_bubble = 1'b1;
                        end else begin
                            // Pipeline advances so EX/MEM captures the result.
                            ex_done = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Saturating count of cycles in which the PC was held.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
        end else if (pc_stall && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    assign pipe.pc_stall_o     = pc_stall;
    assign pipe.ifid_stall_o   = ifid_stall;
    assign pipe.idex_stall_o   = idex_stall;
    assign pipe.ifid_flush_o   = ifid_flush;
    assign pipe.idex_flush_o   = idex_flush;
    assign pipe.exmem_bubble_o = exmem_bubble;
    assign pipe.ex_busy_o      = ex_busy;
    assign pipe.ex_done_o      = ex_done;
    assign pipe.stall_cnt_o    = stall_cnt;
endmodule

// File: doc/ex_pipe_ctrl.md
Name: ex_pipe_ctrl

Overview:
Pipeline sequencing controller for the execute stage. It generates the stall, flush and bubble controls for the PC, IF/ID, ID/EX and EX/MEM registers around the EX datapath, covering three cases:
- load-use hazards;
- multi-cycle EX operations (e.g. MUL), which hold the EX stage for a fixed latency;
- taken-branch redirects resolved in MEM.

It also keeps a saturating stall-cycle performance counter.

Parameters:
MUL_LAT, 4, total EX occupancy in cycles of a multi-cycle op; legal range 2..15
CNT_W, 16, width of stall performance counter

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
id_valid_i  in  1  valid instruction in ID stage
id_rs1_i  in  5  ID source register 1 address
id_rs2_i  in  5  ID source register 2 address
ex_MemRead_i  in  1  EX instruction is a load
ex_waddr_i  in  5  EX destination register address
ex_multi_i  in  1  EX instruction is multi-cycle
mem_branch_taken_i  in  1  branch in MEM resolved taken (zero/non-zero/unconditional)
pc_stall_o  out  1  hold PC
ifid_stall_o  out  1  hold IF/ID register
idex_stall_o  out  1  hold ID/EX register
ifid_flush_o  out  1  clear IF/ID to bubble
idex_flush_o  out  1  clear ID/EX to bubble
exmem_bubble_o  out  1  load EX/MEM with bubble (all write/mem/branch controls 0)
ex_busy_o  out  1  multi-cycle op in progress
ex_done_o  out  1  final cycle of a multi-cycle op; EX result valid for EX/MEM capture
stall_cnt_o  out  CNT_W  stall-cycle counter

Behaviour:
- State: FSM {RUN, MULTI} and a 4-bit down counter cnt.
- Reset (reset=0, async): state=RUN, cnt=0, stall_cnt_o=0. While reset is low, all outputs are forced to 0.
- All control outputs are combinational from state, cnt and the current-cycle inputs. Register stages act on them at the next rising edge.
- Priority: flush > multi-cycle > load-use.
- Flush condition, any state: mem_branch_taken_i=1.
  - ifid_flush_o=1, idex_flush_o=1, exmem_bubble_o=1.
  - All stalls 0.
  - Next state RUN, cnt cleared. Any in-flight multi-cycle op is aborted with no ex_done_o.
- Multi-cycle entry: state RUN, ex_multi_i=1, no flush.
  - pc_stall_o, ifid_stall_o, idex_stall_o, exmem_bubble_o, ex_busy_o all = 1.
  - Next state MULTI, cnt=MUL_LAT-2.
- MULTI with cnt!=0, no flush:
  - Same stall/bubble/busy outputs as entry.
  - cnt decrements.
- MULTI with cnt==0, no flush:
  - ex_done_o=1, ex_busy_o=1.
  - All stalls and bubble 0, so the pipeline advances and EX/MEM captures the result.
  - Next state RUN.
  - In the following RUN cycle, ex_multi_i refers to the next instruction.
- Op timing: total EX occupancy is exactly MUL_LAT cycles, with MUL_LAT-1 stall cycles. For MUL_LAT=2, the entry cycle is followed directly by the done cycle.
- Load-use: state RUN, no flush, ex_multi_i=0, and all of the following:
  - ex_MemRead_i=1;
  - ex_waddr_i!=31 (XZR never hazards);
  - id_valid_i=1;
  - id_rs1_i==ex_waddr_i or id_rs2_i==ex_waddr_i.
- Load-use response: pc_stall_o=1, ifid_stall_o=1, idex_flush_o=1 (bubble into EX). idex_stall_o=0.
- Load-use lasts exactly one cycle, because the load moves to MEM.
- ex_multi_i and ex_MemRead_i both 1 is illegal decode; multi-cycle handling applies.
- When no condition applies, all controls are 0.
- stall_cnt_o increments by 1 on each rising edge where pc_stall_o=1. It saturates at all-ones and does not wrap.
- Reset asserted mid-op: the op is aborted immediately, the FSM returns to RUN and the counter is cleared.

Test Plan:
- Reset: hold reset=0 with random inputs -> all outputs 0, stall_cnt_o=0; release -> state RUN.
- Load-use: ex_MemRead_i=1, ex_waddr_i=5, id_valid_i=1, id_rs2_i=5 -> one cycle of pc_stall_o=ifid_stall_o=idex_flush_o=1; stall_cnt_o=1. Repeat with ex_waddr_i=31 -> no stall.
- Multi-cycle with MUL_LAT=4: ex_multi_i=1 at cycle 0 ->
  - cycles 0-2: all stalls, exmem_bubble_o and ex_busy_o =1;
  - cycle 3: ex_done_o=1, stalls 0;
  - stall_cnt_o=3.
- Flush abort: mem_branch_taken_i=1 in the entry cycle of a multi-cycle op -> flushes asserted, no MULTI entry, no ex_done_o. Repeat with a forced branch in MULTI at cnt=1 -> returns to RUN, no ex_done_o.
- Priority: load-use condition and mem_branch_taken_i together -> flush outputs only, pc_stall_o=0.
- Saturation: with CNT_W=4, run 20 stall cycles -> stall_cnt_o stays at 4'hF.
